// File: rtl/arb_pkg.sv
// Shared types and the circular-priority pick helper for rr_multi_arbitrator.
// The fixed-priority variant (ARB_FIXED_PRIO_EN) reuses the same helper with ptr=0.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int MAX_PORTS = 32;
  localparam int PW        = $clog2(MAX_PORTS);

  // Returns the first set bit of req at or after ptr, wrapping at nports; 0 if none set.
  function automatic int unsigned rr_pick(input logic [MAX_PORTS-1:0] req,
                                          input int unsigned          ptr,
                                          input int unsigned          nports);
    int unsigned idx;
    int unsigned res;
    res = 0;
    // Walk from lowest to highest priority so the last hit wins.
    for (int unsigned k = 0; k < MAX_PORTS; k++) begin
      if (k < nports) begin
        idx = ptr + (nports - 1 - k);
        if (idx >= nports) idx = idx - nports;
        if (req[idx[PW-1:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_multi_arbitrator_if.sv
// Requester-side and L2-side bus of rr_multi_arbitrator.
// slave = arbiter view, master = requesters plus L2 model.
interface rr_multi_arbitrator_if #(
  parameter int NPORTS = 4,
  parameter int N      = 32,
  parameter int WPL    = 2
);
  logic [NPORTS-1:0][N-1:0]          addr_req;
  logic [NPORTS-1:0][WPL-1:0][N-1:0] data_in_req;
  logic [NPORTS-1:0]                 re_req;
  logic [NPORTS-1:0]                 we_req;
  logic [NPORTS-1:0][WPL-1:0][N-1:0] data_out_req;
  logic [NPORTS-1:0]                 hit_req;
  logic [NPORTS-1:0]                 ready_req;
  logic [$clog2(NPORTS)-1:0]         grant_id;
  logic                              busy;
  logic [N-1:0]                      addr;
  logic [WPL-1:0][N-1:0]             data_in;
  logic                              re;
  logic                              we;
  logic [WPL-1:0][N-1:0]             data_out;
  logic                              hit;

  modport slave (
    input  addr_req, data_in_req, re_req, we_req, data_out, hit,
    output data_out_req, hit_req, ready_req, grant_id, busy, addr, data_in, re, we
  );

  modport master (
    output addr_req, data_in_req, re_req, we_req, data_out, hit,
    input  data_out_req, hit_req, ready_req, grant_id, busy, addr, data_in, re, we
  );
endinterface

// File: rtl/rr_pick_core.sv
// Combinational circular priority encoder: first requester at or after ptr.
module rr_pick_core
  import arb_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int IW     = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [IW-1:0]     idx_o,
  output logic              valid_o
);
  logic [MAX_PORTS-1:0] req_ext;
  logic [31:0]          ptr_ext;

  assign req_ext = MAX_PORTS'(req_i);
  assign ptr_ext = 32'(ptr_i);
  assign valid_o = |req_i;
  assign idx_o   = IW'(rr_pick(req_ext, ptr_ext, NPORTS));
endmodule

// File: rtl/rr_multi_arbitrator.sv
// NPORTS-way round-robin arbiter onto one L2 port with bounded hold and a turnaround IDLE.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins priority (preemption still honoured).
module rr_multi_arbitrator
  import arb_pkg::*;
#(
  parameter int NPORTS    = 4,
  parameter int N         = 32,
  parameter int BLOCKSIZE = 8,
  parameter int WORDSIZE  = 4,
  parameter int MAX_HOLD  = 16
) (
  input logic                  clk,
  input logic                  rst,
  rr_multi_arbitrator_if.slave bus
);
  localparam int WPL = BLOCKSIZE / WORDSIZE;
  localparam int IW  = $clog2(NPORTS);
  localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_PORT = IW'(NPORTS - 1);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [NPORTS-1:0] req, pick_req, others;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld, release_w, preempt_w;

  assign req       = bus.re_req | bus.we_req;
  assign others    = req & ~(NPORTS'(1) << grant_q);
  assign release_w = !req[grant_q];
  assign preempt_w = (hold_q == HOLD_LAST) && (|others);

`ifdef ARB_FIXED_PRIO_EN
  // A preempted port sits out the next pick so the waiting port actually gets in.
  logic [NPORTS-1:0] excl_q, excl_d;
  assign pick_req = ((req & ~excl_q) != '0) ? (req & ~excl_q) : req;
`else
  assign pick_req = req;
`endif

  rr_pick_core #(.NPORTS(NPORTS), .IW(IW)) u_pick (
    .req_i  (pick_req),
    .ptr_i  (rr_ptr_q),
    .idx_o  (pick_idx),
    .valid_o(pick_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
`ifdef ARB_FIXED_PRIO_EN
      excl_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
`ifdef ARB_FIXED_PRIO_EN
      excl_q   <= excl_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
`ifdef ARB_FIXED_PRIO_EN
    excl_d   = excl_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          grant_d = pick_idx;
          hold_d  = '0;
`ifdef ARB_FIXED_PRIO_EN
          excl_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (release_w || preempt_w) begin
          state_d = IDLE;
          grant_d = '0;
          hold_d  = '0;
`ifdef ARB_FIXED_PRIO_EN
          rr_ptr_d = '0;
          excl_d   = release_w ? '0 : (NPORTS'(1) << grant_q);
`else
          rr_ptr_d = (grant_q == LAST_PORT) ? '0 : grant_q + IW'(1);
`endif
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // L2-side mux: pure pass-through of the owner's live inputs.
  always_comb begin
    bus.addr    = '0;
    bus.data_in = '0;
    bus.re      = 1'b0;
    bus.we      = 1'b0;
    if (state_q == GRANT) begin
      bus.addr    = bus.addr_req[grant_q];
      bus.data_in = bus.data_in_req[grant_q];
      bus.re      = bus.re_req[grant_q];
      bus.we      = bus.we_req[grant_q];
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic own;
    assign own                 = (state_q == GRANT) && (grant_q == IW'(p));
    assign bus.ready_req[p]    = own;
    assign bus.hit_req[p]      = own & bus.hit;
    assign bus.data_out_req[p] = own ? bus.data_out : '0;
  end

  assign bus.grant_id = grant_q;
  assign bus.busy     = (state_q == GRANT);

  logic [WPL-1:0][N-1:0] unused_w;
  assign unused_w = '0;
endmodule
